// File: rtl/layer_seq_pkg.sv
`default_nettype none
//==============================================================================
// layer_seq_pkg - descriptor layout, FSM states and geometry widths   rev 1.0
//==============================================================================
package layer_seq_pkg;

  localparam int DESC_W = 96;

  localparam int SS_W = 12;
  localparam int ID_W = 4;
  localparam int IS_W = 10;
  localparam int IH_W = 5;
  localparam int IW_W = 5;
  localparam int DS_W = 12;
  localparam int OD_W = 4;
  localparam int OS_W = 10;
  localparam int OH_W = 5;
  localparam int OW_W = 5;
  localparam int FS_W = 8;
  localparam int KS_W = 5;
  localparam int KH_W = 3;
  localparam int KW_W = 3;

  typedef struct packed {
    logic            spare;
    logic            has_w;
    logic            has_b;
    logic            backprop;
    logic            enbias;
    logic [SS_W-1:0] ss;
    logic [ID_W-1:0] id;
    logic [IS_W-1:0] is;
    logic [IH_W-1:0] ih;
    logic [IW_W-1:0] iw;
    logic [DS_W-1:0] ds;
    logic [OD_W-1:0] od;
    logic [OS_W-1:0] os;
    logic [OH_W-1:0] oh;
    logic [OW_W-1:0] ow;
    logic [FS_W-1:0] fs;
    logic [KS_W-1:0] ks;
    logic [KH_W-1:0] kh;
    logic [KW_W-1:0] kw;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WLOAD = 3'd2,
    ST_BLOAD = 3'd3,
    ST_RUN   = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/layer_seq_if.sv
`default_nettype none
//==============================================================================
// layer_seq_if - stream handshake observation, mode strobes and geometry   rev 1.0
//==============================================================================
interface layer_seq_if;
  import layer_seq_pkg::*;

  logic src_valid, src_ready, src_last;
  logic dst_valid, dst_ready, dst_last;
  logic wwrite, bwrite, run, backprop, enbias;
  logic [SS_W-1:0] ss;
  logic [ID_W-1:0] id;
  logic [IS_W-1:0] is;
  logic [IH_W-1:0] ih;
  logic [IW_W-1:0] iw;
  logic [DS_W-1:0] ds;
  logic [OD_W-1:0] od;
  logic [OS_W-1:0] os;
  logic [OH_W-1:0] oh;
  logic [OW_W-1:0] ow;
  logic [FS_W-1:0] fs;
  logic [KS_W-1:0] ks;
  logic [KH_W-1:0] kh;
  logic [KW_W-1:0] kw;

  modport master (
    input  src_valid, src_ready, src_last, dst_valid, dst_ready, dst_last,
    output wwrite, bwrite, run, backprop, enbias,
    output ss, id, is, ih, iw, ds, od, os, oh, ow, fs, ks, kh, kw
  );

  modport slave (
    output src_valid, src_ready, src_last, dst_valid, dst_ready, dst_last,
    input  wwrite, bwrite, run, backprop, enbias,
    input  ss, id, is, ih, iw, ds, od, os, oh, ow, fs, ks, kh, kw
  );

endinterface
`default_nettype wire

// File: rtl/layer_seq_table.sv
`default_nettype none
//==============================================================================
// layer_seq_table - LAYERS x 96 descriptor file, 1 write / 1 async read   rev 1.0
//==============================================================================
module layer_seq_table
  import layer_seq_pkg::*;
#(
  parameter int LAYERS = 4
) (
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] wr_addr,
  input  desc_t      wr_data,
  input  logic [2:0] rd_addr,
  output desc_t      rd_data
);

  desc_t r_mem [LAYERS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LAYERS; i++) begin
      if (we && (wr_addr == 3'(i))) r_mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (rd_addr == 3'(i)) rd_data = r_mem[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/layer_seq.sv
`default_nettype none
//==============================================================================
// layer_seq - layer sequencer; optional LAYER_SEQ_PERF_EN cycle counter   rev 1.0
//==============================================================================
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter int LAYERS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DESC_W-1:0] cfg_data,
  output logic              cfg_err,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        num_layers,
  output logic              busy,
  output logic              done,
  output logic [2:0]        cur_layer,
  output logic [31:0]       perf_cyc,
  layer_seq_if.master       bus
);

  localparam logic [3:0] c_layers = 4'(LAYERS);

  state_t     r_state, w_next_state, r_gap_from;
  desc_t      w_rd_desc, r_desc;
  logic [2:0] r_layer;
  logic [3:0] r_num;
  logic       r_wwrite, r_bwrite, r_run, r_backprop, r_enbias, r_done, r_cfg_err;
  logic       w_src_last, w_dst_last, w_start_acc, w_addr_ok, w_tbl_we, w_bp, w_eb;
  logic       w_unused;

  layer_seq_table #(.LAYERS(LAYERS)) u_table (
    .clk     (clk),
    .we      (w_tbl_we),
    .wr_addr (cfg_addr),
    .wr_data (desc_t'(cfg_data)),
    .rd_addr (r_layer),
    .rd_data (w_rd_desc)
  );

  assign w_src_last  = bus.src_valid & bus.src_ready & bus.src_last;
  assign w_dst_last  = bus.dst_valid & bus.dst_ready & bus.dst_last;
  assign w_start_acc = (r_state == ST_IDLE) & start & ~abort;
  assign w_addr_ok   = ({1'b0, cfg_addr} < c_layers);
  assign w_tbl_we    = cfg_we & w_addr_ok & (r_state == ST_IDLE);

  // Leaving LOAD the descriptor is not latched yet, so RUN flags come from the table.
  assign w_bp = (r_state == ST_LOAD) ? w_rd_desc.backprop : r_desc.backprop;
  assign w_eb = (r_state == ST_LOAD) ? w_rd_desc.enbias   : r_desc.enbias;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = (num_layers == 4'd0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  begin
        if (w_rd_desc.has_w)      w_next_state = ST_WLOAD;
        else if (w_rd_desc.has_b) w_next_state = ST_BLOAD;
        else                      w_next_state = ST_RUN;
      end
      ST_WLOAD, ST_BLOAD: if (w_src_last) w_next_state = ST_GAP;
      ST_RUN:   if (w_dst_last) w_next_state = ST_GAP;
      ST_GAP:   begin
        if (r_gap_from == ST_WLOAD && r_desc.has_b)    w_next_state = ST_BLOAD;
        else if (r_gap_from != ST_RUN)                 w_next_state = ST_RUN;
        else if (({1'b0, r_layer} + 4'd1) < r_num)     w_next_state = ST_LOAD;
        else                                           w_next_state = ST_DONE;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
    if (abort) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_from <= ST_IDLE;
      r_desc     <= '0;
      r_layer    <= '0;
      r_num      <= '0;
      r_wwrite   <= 1'b0;
      r_bwrite   <= 1'b0;
      r_run      <= 1'b0;
      r_backprop <= 1'b0;
      r_enbias   <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      if (r_state inside {ST_WLOAD, ST_BLOAD, ST_RUN}) r_gap_from <= r_state;
      if (r_state == ST_LOAD) r_desc <= w_rd_desc;
      if (w_start_acc) begin
        r_layer <= '0;
        r_num   <= (num_layers > c_layers) ? c_layers : num_layers;
      end else if (r_state == ST_GAP && w_next_state == ST_LOAD) begin
        r_layer <= r_layer + 3'd1;
      end
      r_wwrite   <= (w_next_state == ST_WLOAD);
      r_bwrite   <= (w_next_state == ST_BLOAD);
      r_run      <= (w_next_state == ST_RUN);
      r_backprop <= (w_next_state == ST_RUN) & w_bp;
      r_enbias   <= (w_next_state == ST_RUN) & w_eb;
      r_done     <= (r_state == ST_DONE) & ~abort;
      r_cfg_err  <= cfg_we & ~(w_addr_ok & (r_state == ST_IDLE));
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] r_perf;

  // The accepting cycle counts as the first cycle of the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_perf <= '0;
    else if (w_start_acc)         r_perf <= 32'd1;
    else if (r_state != ST_IDLE)  r_perf <= r_perf + 32'd1;
  end
  assign perf_cyc = r_perf;
`else
  assign perf_cyc = '0;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;
  assign cur_layer = r_layer;
  assign w_unused  = r_desc.spare ^ r_desc.has_w;

  assign bus.wwrite   = r_wwrite;
  assign bus.bwrite   = r_bwrite;
  assign bus.run      = r_run;
  assign bus.backprop = r_backprop;
  assign bus.enbias   = r_enbias;
  assign bus.ss = r_desc.ss;
  assign bus.id = r_desc.id;
  assign bus.is = r_desc.is;
  assign bus.ih = r_desc.ih;
  assign bus.iw = r_desc.iw;
  assign bus.ds = r_desc.ds;
  assign bus.od = r_desc.od;
  assign bus.os = r_desc.os;
  assign bus.oh = r_desc.oh;
  assign bus.ow = r_desc.ow;
  assign bus.fs = r_desc.fs;
  assign bus.ks = r_desc.ks;
  assign bus.kh = r_desc.kh;
  assign bus.kw = r_desc.kw;

endmodule
`default_nettype wire

// File: tb/tb_layer_seq.sv
`default_nettype none
//==============================================================================
// tb_layer_seq - directed self-checking bench for layer_seq   rev 1.0
//==============================================================================
module tb_layer_seq;
  import layer_seq_pkg::*;

  localparam int LAYERS = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_addr = '0;
  logic [DESC_W-1:0] cfg_data = '0;
  logic              cfg_err;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        num_layers = '0;
  logic              busy, done;
  logic [2:0]        cur_layer;
  logic [31:0]       perf_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  desc_t d0, d1, d2, d3;

  layer_seq_if bus ();

  layer_seq #(.LAYERS(LAYERS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .start      (start),
    .abort      (abort),
    .num_layers (num_layers),
    .busy       (busy),
    .done       (done),
    .cur_layer  (cur_layer),
    .perf_cyc   (perf_cyc),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic desc_t mk(input logic hw, hb, bp, eb,
                               input logic [11:0] ss, input logic [3:0] id, input logic [9:0] is,
                               input logic [4:0] ih, iw, input logic [11:0] ds, input logic [3:0] od,
                               input logic [9:0] os, input logic [4:0] oh, ow, input logic [7:0] fs,
                               input logic [4:0] ks, input logic [2:0] kh, kw);
    desc_t d;
    d = '0;
    d.has_w = hw; d.has_b = hb; d.backprop = bp; d.enbias = eb;
    d.ss = ss; d.id = id; d.is = is; d.ih = ih; d.iw = iw;
    d.ds = ds; d.od = od; d.os = os; d.oh = oh; d.ow = ow;
    d.fs = fs; d.ks = ks; d.kh = kh; d.kw = kw;
    return d;
  endfunction

  function automatic logic [4:0] strb();
    return {bus.wwrite, bus.bwrite, bus.run, bus.backprop, bus.enbias};
  endfunction

  function automatic logic [90:0] geom_now();
    return {bus.ss, bus.id, bus.is, bus.ih, bus.iw, bus.ds, bus.od,
            bus.os, bus.oh, bus.ow, bus.fs, bus.ks, bus.kh, bus.kw};
  endfunction

  function automatic logic [90:0] geom_of(input desc_t d);
    return {d.ss, d.id, d.is, d.ih, d.iw, d.ds, d.od, d.os, d.oh, d.ow, d.fs, d.ks, d.kh, d.kw};
  endfunction

  task automatic set_src(input logic v, r, l);
    bus.src_valid = v; bus.src_ready = r; bus.src_last = l;
  endtask

  task automatic set_dst(input logic v, r, l);
    bus.dst_valid = v; bus.dst_ready = r; bus.dst_last = l;
  endtask

  task automatic wr(input logic [2:0] a, input desc_t d, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
  endtask

  task automatic go(input logic [3:0] n);
    start = 1'b1; num_layers = n;
    step();
    start = 1'b0;
  endtask

  // Holds the phase for `hold` cycles (first one a last-without-ready beat, plus
  // a full last beat on the other channel), then completes it; ends in GAP.
  task automatic phase(input string tag, input logic [4:0] exp, input bit on_dst,
                       input int hold, input bit ab);
    for (int k = 0; k < hold; k++) begin
      if (on_dst) begin set_dst(1'b1, k != 0, k == 0); set_src(1'b1, 1'b1, 1'b1); end
      else        begin set_src(1'b1, k != 0, k == 0); set_dst(1'b1, 1'b1, 1'b1); end
      step();
      chk({tag, "_hold"}, strb(), exp);
    end
    if (on_dst) begin set_dst(1'b1, 1'b1, 1'b1); set_src(1'b0, 1'b0, 1'b0); end
    else        begin set_src(1'b1, 1'b1, 1'b1); set_dst(1'b0, 1'b0, 1'b0); end
    abort = ab;
    step();
    set_src(1'b0, 1'b0, 1'b0); set_dst(1'b0, 1'b0, 1'b0); abort = 1'b0;
    chk({tag, "_gap"}, strb(), 5'b0);
  endtask

  // Entered in the LOAD cycle of layer idx; returns in the GAP after RUN.
  task automatic do_layer(input desc_t d, input logic [2:0] idx, input bit ab);
    chk("load_idx", cur_layer, idx);
    chk("load_strb", strb(), 5'b0);
    chk("load_busy", busy, 1'b1);
    step();
    if (d.has_w) begin
      chk("w_strb", strb(), 5'b10000);
      chk("w_geom", geom_now(), geom_of(d));
      phase("w", 5'b10000, 1'b0, 1, 1'b0);
      step();
    end
    if (d.has_b) begin
      chk("b_strb", strb(), 5'b01000);
      chk("b_geom", geom_now(), geom_of(d));
      phase("b", 5'b01000, 1'b0, 1, 1'b0);
      step();
    end
    chk("run_strb", strb(), {3'b001, d.backprop, d.enbias});
    chk("run_geom", geom_now(), geom_of(d));
    phase("run", {3'b001, d.backprop, d.enbias}, 1'b1, 1, ab);
  endtask

  initial begin
    d0 = mk(1, 1, 0, 1, 12'h123, 4'h4, 10'h155, 5'd7, 5'd9, 12'hABC, 4'h2, 10'h2AA,
            5'd3, 5'd5, 8'h5A, 5'd17, 3'd3, 3'd5);
    d1 = mk(0, 0, 1, 0, 12'h0F0, 4'hF, 10'h3FF, 5'd31, 5'd1, 12'h001, 4'h8, 10'h001,
            5'd16, 5'd8, 8'hFF, 5'd0, 3'd7, 3'd1);
    d2 = mk(0, 0, 0, 1, 12'h7FF, 4'h1, 10'h010, 5'd2, 5'd2, 12'h800, 4'h3, 10'h100,
            5'd1, 5'd1, 8'h01, 5'd31, 3'd1, 3'd0);
    d3 = mk(1, 0, 1, 1, 12'hFFF, 4'h9, 10'h0AA, 5'd12, 5'd20, 12'h5A5, 4'hC, 10'h333,
            5'd30, 5'd29, 8'h80, 5'd9, 3'd4, 3'd6);
    set_src(1'b0, 1'b0, 1'b0);
    set_dst(1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_layer", cur_layer, 3'd0);
    chk("rst_strb", strb(), 5'b0);
    chk("rst_geom", geom_now(), 91'd0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_perf", perf_cyc, 32'd0);

    // Two-layer pass: W, B, RUN on L0, then RUN with backprop on L1
    wr(3'd0, d0, 1'b0);
    wr(3'd1, d1, 1'b0);
    go(4'd2);
    do_layer(d0, 3'd0, 1'b0);
    step();
    do_layer(d1, 3'd1, 1'b0);
    chk("fin_gap_done", done, 1'b0);
    chk("fin_gap_busy", busy, 1'b1);
    step();
    chk("fin_done_state_busy", busy, 1'b1);
    chk("fin_done_state_done", done, 1'b0);
    step();
    chk("fin_done", done, 1'b1);
    chk("fin_busy", busy, 1'b0);
    chk("fin_layer", cur_layer, 3'd1);
    chk("idle_geom_hold", geom_now(), geom_of(d1));
    step();
    chk("fin_done_clr", done, 1'b0);

    // num_layers = 0, with a write attempted while busy
    go(4'd0);
    chk("zero_busy", busy, 1'b1);
    chk("zero_strb", strb(), 5'b0);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = d3;
    step();
    cfg_we = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_idle", busy, 1'b0);
    chk("busy_wr_err", cfg_err, 1'b1);
    chk("zero_strb2", strb(), 5'b0);
    step();
    chk("zero_done_clr", done, 1'b0);
    chk("busy_wr_err_clr", cfg_err, 1'b0);

    // Out-of-range address, then fill the rest of the table
    wr(3'd5, d3, 1'b1);
    wr(3'd2, d2, 1'b0);
    wr(3'd3, d3, 1'b0);

    // num_layers above LAYERS clamps to 4; L1 must still hold d1
    go(4'd15);
    do_layer(d0, 3'd0, 1'b0);
    step();
    do_layer(d1, 3'd1, 1'b0);
    step();
    do_layer(d2, 3'd2, 1'b0);
    step();
    do_layer(d3, 3'd3, 1'b0);
    step();
    chk("clamp_done_state", done, 1'b0);
    step();
    chk("clamp_done", done, 1'b1);
    chk("clamp_layer", cur_layer, 3'd3);

    // Abort on the final RUN last beat of layer 1
    go(4'd2);
    do_layer(d0, 3'd0, 1'b0);
    step();
    do_layer(d1, 3'd1, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_layer", cur_layer, 3'd1);
    step();
    chk("abort_no_done1", done, 1'b0);
    step();
    chk("abort_no_done2", done, 1'b0);

    // Asynchronous reset in the middle of WLOAD
    go(4'd1);
    step();
    chk("pre_rst_wwrite", bus.wwrite, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strb", strb(), 5'b0);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    chk("rst2_geom", geom_now(), 91'd0);
    chk("rst2_layer", cur_layer, 3'd0);
    chk("rst2_perf", perf_cyc, 32'd0);
    rst_n = 1'b1;
    step();
    go(4'd1);
    do_layer(d0, 3'd0, 1'b0);
    step();
    step();
    chk("post_rst_done", done, 1'b1);

    // Single run-only layer, last beat 10 cycles after run rises
    wr(3'd0, d1, 1'b0);
    go(4'd1);
    step();
    chk("perf_run_strb", strb(), 5'b00110);
    phase("perf_run", 5'b00110, 1'b1, 10, 1'b0);
    step();
    step();
    chk("perf_done", done, 1'b1);
`ifdef LAYER_SEQ_PERF_EN
    chk("perf_cyc", perf_cyc, 32'd15);
`else
    chk("perf_cyc", perf_cyc, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
